// File: rtl/instr_fetch_128_if.sv
// Program-ROM read port, instruction handshake and branch redirect between
// the fetch sequencer (master) and its ROM/execute neighbours (slave).
interface instr_fetch_128_if;
    logic [7:0] address;
    logic [7:0] rom_data;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] opcode;
    logic [7:0] operand;
    logic [7:0] instr_pc;
    logic       illegal;
    logic       redirect_valid;
    logic [7:0] redirect_addr;

    modport master (
        output address, instr_valid, opcode, operand, instr_pc, illegal,
        input  rom_data, instr_ready, redirect_valid, redirect_addr
    );

    modport slave (
        input  address, instr_valid, opcode, operand, instr_pc, illegal,
        output rom_data, instr_ready, redirect_valid, redirect_addr
    );
endinterface

// File: rtl/instr_fetch_128.sv
// Instruction fetch sequencer: walks the PC over a registered program ROM,
// assembles 1/2-byte instructions and hands them to execute via valid/ready.
module instr_fetch_128 #(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter int         ADDR_BITS = 7
) (
    input logic              clk,
    input logic              reset_n,
    instr_fetch_128_if.master bus
);
    typedef enum logic [1:0] {S_REQ, S_OPC, S_OPD, S_OUT} state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] pc;
    logic [7:0]           opcode_q;
    logic [7:0]           operand_q;
    logic [7:0]           instr_pc_q;
    logic                 illegal_q;
    logic                 valid_q;
    logic                 unused_addr_msb;

    function automatic logic is_two_byte(input logic [7:0] op);
        return op inside {[8'h10:8'h15], [8'h30:8'h38]};
    endfunction

    function automatic logic is_legal(input logic [7:0] op);
        return is_two_byte(op) || (op inside {[8'h20:8'h27]});
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_REQ;
            pc         <= RESET_PC[ADDR_BITS-1:0];
            opcode_q   <= '0;
            operand_q  <= '0;
            instr_pc_q <= '0;
            illegal_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else if (bus.redirect_valid) begin
            // Redirect wins in every state; any half-built instruction is dropped.
            state   <= S_REQ;
            pc      <= bus.redirect_addr[ADDR_BITS-1:0];
            valid_q <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    instr_pc_q <= 8'(pc);
                    pc         <= pc + ADDR_BITS'(1);
                    state      <= S_OPC;
                end
                S_OPC: begin
                    opcode_q  <= bus.rom_data;
                    illegal_q <= !is_legal(bus.rom_data);
                    if (is_two_byte(bus.rom_data)) begin
                        // ROM is latching PC (the operand byte) on this same edge.
                        pc    <= pc + ADDR_BITS'(1);
                        state <= S_OPD;
                    end else begin
                        operand_q <= '0;
                        valid_q   <= 1'b1;
                        state     <= S_OUT;
                    end
                end
                S_OPD: begin
                    operand_q <= bus.rom_data;
                    valid_q   <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (bus.instr_ready) begin
                        valid_q <= 1'b0;
                        state   <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    assign bus.address     = 8'(pc);
    assign bus.instr_valid = valid_q;
    assign bus.opcode      = opcode_q;
    assign bus.operand     = operand_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.illegal     = illegal_q;

    assign unused_addr_msb = bus.redirect_addr[7];
endmodule
